mem_stage_ws: RTL

- Parametrised memory-access stage with a word-addressed data memory and a programmable wait-state count.
- Maps the ALU-computed byte address to a word index, performs the load or store after WAIT_CYCLES, and holds the pipeline through a mem_ready stall signal.
- Sits between EXE and WB.
- Successor to the fixed single-cycle memory stage: width, depth, base and latency are configurable, and a multi-cycle handshake is added.

---
 rtl/mem_stage_ws.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_ws.sv
// Multi-cycle memory-access stage between EXE and WB with WAIT_CYCLES wait states and a mem_ready stall.
// Optional MEM_RANGE_CHECK_EN: flag out-of-window/misaligned accesses on err instead of wrapping.
module mem_stage_ws #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 64,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_w_en,
    input  logic              mem_r_en,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] ST_value,
    output logic [DATA_W-1:0] memory_result,
    output logic              mem_ready,
    output logic              err
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [DATA_W-1:0] BASE_L = DATA_W'(BASE_ADDR);
    localparam logic [7:0]        WAIT_L = 8'(WAIT_CYCLES);
`ifdef MEM_RANGE_CHECK_EN
    localparam logic [DATA_W-1:0] SPAN_L     = DATA_W'(DEPTH * BYTES);
    localparam logic [DATA_W-1:0] OFF_MASK_L = DATA_W'(BYTES - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              store_q, store_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [DATA_W-1:0] offset_s;
    logic [DATA_W-1:0] word_off_s;
    logic [IDX_W-1:0]  idx_s;
    logic              req_s;
    logic              access_s;
    logic              range_err_s;
    logic              wr_en_s;
    logic              unused_s;

    assign req_s      = mem_r_en | mem_w_en;
    assign offset_s   = addr_q - BASE_L;
    assign word_off_s = offset_s >> OFF_W;
    assign idx_s      = word_off_s[IDX_W-1:0];
    assign access_s   = (state_q == S_BUSY) && (cnt_q == 8'd0);
    assign unused_s   = ^word_off_s;

`ifdef MEM_RANGE_CHECK_EN
    // Checked on the subtracted offset so BASE+span overflow cannot alias.
    assign range_err_s = (addr_q < BASE_L) || (offset_s >= SPAN_L)
                         || ((addr_q & OFF_MASK_L) != {DATA_W{1'b0}});
`else
    assign range_err_s = 1'b0;
`endif

    assign wr_en_s       = access_s && store_q && !range_err_s;
    assign memory_result = result_q;
    assign err           = err_q;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_s) begin
                    state_d = S_BUSY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_BUSY;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: stall while a request is pending or in flight.
    always_comb begin
        mem_ready = 1'b1;
        case (state_q)
            S_IDLE:  mem_ready = ~req_s;
            S_BUSY:  mem_ready = 1'b0;
            S_DONE:  mem_ready = 1'b1;
            default: mem_ready = 1'b1;
        endcase
    end

    // Datapath next-state: latch request in IDLE, count down and access in BUSY.
    always_comb begin
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        store_d  = store_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_s) begin
                    addr_d  = alu_result;
                    data_d  = ST_value;
                    store_d = mem_w_en;
                    cnt_d   = WAIT_L;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_BUSY: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    err_d = range_err_s;
                    if (store_q) begin
                        result_d = result_q;
                    end else if (range_err_s) begin
                        result_d = {DATA_W{1'b0}};
                    end else begin
                        result_d = mem_q[idx_s];
                    end
                end
            end
            S_DONE:  cnt_d = cnt_q;
            default: cnt_d = cnt_q;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q    <= 8'd0;
            addr_q   <= {DATA_W{1'b0}};
            data_q   <= {DATA_W{1'b0}};
            store_q  <= 1'b0;
            result_q <= {DATA_W{1'b0}};
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            store_q  <= store_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // Data array; reset wipes every word so an aborted store leaves nothing behind.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_en_s) begin
            mem_q[idx_s] <= data_q;
        end
    end

endmodule
